// File: rtl/dcache_stall_unit_pkg.sv
// dcache_pkg: shared types and address helpers for the L1 data cache stall unit.
// Contents: FSM state enum, line geometry constants, and tag/index/word
// extraction functions. The helpers work on a 64-bit zero-extended address so
// the same functions serve any address width; callers size-cast the result.
package dcache_pkg;

    localparam int OFFSET_BITS   = 4;   // 16-byte lines
    localparam int LINE_WORDS    = 4;   // 32-bit words per line
    localparam int WORD_SEL_BITS = 2;
    localparam int WORD_W        = 32;
    localparam int STRB_W        = WORD_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        REFILL,
        RESP,
        WR_REQ,
        WR_DONE
    } dcache_state_e;

    function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int index_bits);
        return addr >> (OFFSET_BITS + index_bits);
    endfunction

    function automatic logic [63:0] addr_index(input logic [63:0] addr, input int index_bits);
        return (addr >> OFFSET_BITS) & ((64'd1 << index_bits) - 64'd1);
    endfunction

    function automatic logic [WORD_SEL_BITS-1:0] addr_word(input logic [63:0] addr);
        return WORD_SEL_BITS'(addr >> 2);
    endfunction

endpackage

// File: rtl/dcache_stall_unit_if.sv
// dcache_stall_unit_if: pipeline request/response and memory-side buses of the
// data cache stall unit.
//   req_*            pipeline load/store request (held stable while stall=1)
//   resp_*, stall    load response and pipeline stall
//   rd_*             line refill request / beat return
//   wr_*             write-through word request
// Modports: slave = cache controller, master = pipeline + memory environment.
interface dcache_stall_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              stall;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic              rd_valid;
    logic [31:0]       rd_data;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic              wr_ready;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output resp_valid, resp_rdata, stall,
        output rd_req, rd_addr,
        input  rd_ready, rd_valid, rd_data,
        output wr_req, wr_addr, wr_data, wr_strb,
        input  wr_ready
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  resp_valid, resp_rdata, stall,
        input  rd_req, rd_addr,
        output rd_ready, rd_valid, rd_data,
        input  wr_req, wr_addr, wr_data, wr_strb,
        output wr_ready
    );
endinterface

// File: rtl/dcache_stall_unit_line_array.sv
// dcache_line_array: tag, valid and data storage for the direct-mapped cache.
// Ports:
//   clk, rst                  clock, synchronous active-high reset (clears all valid bits)
//   index, word_sel           line and word addressed by the held request
//   look_tag/valid/data       combinational read of the addressed line/word
//   st_en, st_data, st_strb   byte-masked write of the addressed word
//   beat_en, beat_word/data   refill beat write into the addressed line
//   inv_en                    clear the addressed line's valid bit
//   fill_en, fill_tag         write the tag and set valid (last refill beat)
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int TAG_W      = 22
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INDEX_BITS-1:0]    index,
    input  logic [WORD_SEL_BITS-1:0] word_sel,
    output logic [TAG_W-1:0]         look_tag,
    output logic                     look_valid,
    output logic [WORD_W-1:0]        look_data,
    input  logic                     st_en,
    input  logic [WORD_W-1:0]        st_data,
    input  logic [STRB_W-1:0]        st_strb,
    input  logic                     beat_en,
    input  logic [WORD_SEL_BITS-1:0] beat_word,
    input  logic [WORD_W-1:0]        beat_data,
    input  logic                     inv_en,
    input  logic                     fill_en,
    input  logic [TAG_W-1:0]         fill_tag
);
    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [WORD_W-1:0] data_q [LINES][LINE_WORDS];

    assign look_tag   = tag_q[index];
    assign look_valid = valid_q[index];
    assign look_data  = data_q[index][word_sel];

    // Only the valid bits need reset; tag/data are meaningless while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[index] <= 1'b1;
        end else if (inv_en) begin
            valid_q[index] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[index] <= fill_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (beat_en) begin
            data_q[index][beat_word] <= beat_data;
        end else if (st_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (st_strb[b]) begin
                    data_q[index][word_sel][8*b +: 8] <= st_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dcache_stall_unit.sv
// dcache_stall_unit: blocking, direct-mapped, write-through, no-write-allocate
// L1 data cache controller. Its stall output is the pipeline's DCache stall.
// Ports:
//   clk   clock
//   rst   synchronous reset, active-high
//   bus   dcache_stall_unit_if.slave (pipeline request/response, refill, write-through)
//
// state   | meaning
// IDLE    | accept a request; hits answer combinationally
// RD_REQ  | refill request outstanding, waiting for rd_ready
// REFILL  | collecting four refill beats, lowest word first
// RESP    | return the refilled word, release the stall
// WR_REQ  | write-through word outstanding, waiting for wr_ready
// WR_DONE | store complete, release the stall
module dcache_stall_unit
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int ADDR_W     = 32
) (
    input logic                clk,
    input logic                rst,
    dcache_stall_unit_if.slave bus
);
    localparam int TAG_W = ADDR_W - OFFSET_BITS - INDEX_BITS;

    dcache_state_e            state_q, state_d;
    logic [WORD_SEL_BITS-1:0] beat_q, beat_d;

    logic [INDEX_BITS-1:0]    req_index;
    logic [TAG_W-1:0]         req_tag;
    logic [WORD_SEL_BITS-1:0] req_word;
    logic [TAG_W-1:0]         look_tag;
    logic                     look_valid;
    logic [WORD_W-1:0]        look_data;
    logic                     hit;

    logic st_en, beat_en, inv_en, fill_en;
    logic resp_c, stall_c, rd_req_c, wr_req_c;

    // The pipeline holds req_* while stalled, so the live request doubles as
    // the transaction register for the whole miss/store sequence.
    assign req_index = INDEX_BITS'(addr_index(64'(bus.req_addr), INDEX_BITS));
    assign req_tag   = TAG_W'(addr_tag(64'(bus.req_addr), INDEX_BITS));
    assign req_word  = addr_word(64'(bus.req_addr));
    assign hit       = look_valid && (look_tag == req_tag);

    dcache_line_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W)
    ) u_lines (
        .clk        (clk),
        .rst        (rst),
        .index      (req_index),
        .word_sel   (req_word),
        .look_tag   (look_tag),
        .look_valid (look_valid),
        .look_data  (look_data),
        .st_en      (st_en),
        .st_data    (bus.req_wdata),
        .st_strb    (bus.req_wstrb),
        .beat_en    (beat_en),
        .beat_word  (beat_q),
        .beat_data  (bus.rd_data),
        .inv_en     (inv_en),
        .fill_en    (fill_en),
        .fill_tag   (req_tag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Everything is held quiet while rst is high so a reset mid-transaction
    // neither writes the array nor leaves a request on the memory side.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        st_en    = 1'b0;
        beat_en  = 1'b0;
        inv_en   = 1'b0;
        fill_en  = 1'b0;
        resp_c   = 1'b0;
        stall_c  = 1'b0;
        rd_req_c = 1'b0;
        wr_req_c = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (bus.req_we) begin
                            st_en   = hit;
                            stall_c = 1'b1;
                            state_d = WR_REQ;
                        end else if (hit) begin
                            resp_c  = 1'b1;
                        end else begin
                            inv_en  = 1'b1;
                            stall_c = 1'b1;
                            state_d = RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    stall_c  = 1'b1;
                    rd_req_c = 1'b1;
                    if (bus.rd_ready) begin
                        beat_d  = '0;
                        state_d = REFILL;
                    end
                end
                REFILL: begin
                    stall_c = 1'b1;
                    if (bus.rd_valid) begin
                        beat_en = 1'b1;
                        beat_d  = beat_q + 2'd1;
                        if (beat_q == 2'd3) begin
                            fill_en = 1'b1;
                            state_d = RESP;
                        end
                    end
                end
                RESP: begin
                    resp_c  = 1'b1;
                    state_d = IDLE;
                end
                WR_REQ: begin
                    stall_c  = 1'b1;
                    wr_req_c = 1'b1;
                    if (bus.wr_ready) begin
                        state_d = WR_DONE;
                    end
                end
                WR_DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Data/address outputs are zeroed when their strobe is low so nothing
    // from uninitialised line storage ever reaches the ports.
    assign bus.resp_valid = resp_c;
    assign bus.resp_rdata = resp_c ? look_data : '0;
    assign bus.stall      = stall_c;
    assign bus.rd_req     = rd_req_c;
    assign bus.rd_addr    = rd_req_c ? {bus.req_addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}} : '0;
    assign bus.wr_req     = wr_req_c;
    assign bus.wr_addr    = wr_req_c ? bus.req_addr  : '0;
    assign bus.wr_data    = wr_req_c ? bus.req_wdata : '0;
    assign bus.wr_strb    = wr_req_c ? bus.req_wstrb : '0;

endmodule

// File: tb/tb_dcache_stall_unit.sv
module tb_dcache_stall_unit;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    dcache_stall_unit_if #(.ADDR_W(32)) bus ();

    dcache_stall_unit #(
        .INDEX_BITS (6),
        .ADDR_W     (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_exp_t;

    logic [31:0] exp_q[$];
    wr_exp_t     wr_q[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        bus.rd_ready  = 1'b0;
        bus.rd_valid  = 1'b0;
        bus.rd_data   = '0;
        bus.wr_ready  = 1'b0;
    endtask

    // Load: expected data is queued at issue and popped when resp_valid shows.
    task automatic do_load(input string name, input logic [31:0] addr, input bit exp_hit,
                           input logic [31:0] beat_base, input logic [31:0] exp_data);
        logic [31:0] exp_v;
        bit          seen;
        bit          go;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = addr;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        exp_q.push_back(exp_data);
        #1;
        go = 1'b1;
        checks++;
        if (exp_hit) begin
            if (bus.stall !== 1'b0 || bus.resp_valid !== 1'b1 || bus.rd_req !== 1'b0) begin
                errors++;
                $display("FAIL %s hit: stall=%b resp_valid=%b rd_req=%b, required 0 1 0",
                         name, bus.stall, bus.resp_valid, bus.rd_req);
            end
        end else begin
            if (bus.stall !== 1'b1 || bus.resp_valid !== 1'b0 || bus.rd_req !== 1'b0) begin
                errors++;
                $display("FAIL %s miss cycle: stall=%b resp_valid=%b rd_req=%b, required 1 0 0",
                         name, bus.stall, bus.resp_valid, bus.rd_req);
            end
            seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                @(negedge clk);
                #1;
                if (bus.rd_req === 1'b1) seen = 1'b1;
            end
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL %s refill request: rd_req never rose, required 1", name);
                void'(exp_q.pop_back());
                go = 1'b0;
            end else begin
                if (bus.rd_addr !== {addr[31:4], 4'h0}) begin
                    errors++;
                    $display("FAIL %s rd_addr: got %h, required %h", name, bus.rd_addr, {addr[31:4], 4'h0});
                end
                // junk beat while not in REFILL must be ignored
                bus.rd_valid = 1'b1;
                bus.rd_data  = 32'hDEAD_BEEF;
                @(negedge clk);
                #1;
                checks++;
                if (bus.rd_req !== 1'b1 || bus.stall !== 1'b1) begin
                    errors++;
                    $display("FAIL %s rd hold: rd_req=%b stall=%b, required 1 1", name, bus.rd_req, bus.stall);
                end
                bus.rd_ready = 1'b1;
                @(negedge clk);
                bus.rd_ready = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (i == 2) begin
                        bus.rd_valid = 1'b0;
                        @(negedge clk);
                    end
                    bus.rd_valid = 1'b1;
                    bus.rd_data  = beat_base + 32'(i);
                    #1;
                    checks++;
                    if (bus.stall !== 1'b1 || bus.resp_valid !== 1'b0 || bus.rd_req !== 1'b0) begin
                        errors++;
                        $display("FAIL %s refill beat %0d: stall=%b resp_valid=%b rd_req=%b, required 1 0 0",
                                 name, i, bus.stall, bus.resp_valid, bus.rd_req);
                    end
                    @(negedge clk);
                end
                bus.rd_valid = 1'b0;
                bus.rd_data  = '0;
                #1;
            end
        end
        if (go) begin
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.stall !== 1'b0) begin
                errors++;
                $display("FAIL %s resp: resp_valid=%b stall=%b, required 1 0", name, bus.resp_valid, bus.stall);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s resp: unexpected response %h, required none", name, bus.resp_rdata);
            end else begin
                exp_v = exp_q.pop_front();
                if (bus.resp_rdata !== exp_v) begin
                    errors++;
                    $display("FAIL %s rdata: got %h, required %h", name, bus.resp_rdata, exp_v);
                end
            end
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic do_store(input string name, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb);
        wr_exp_t exp_w;
        bit      seen;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        bus.req_wstrb = strb;
        wr_q.push_back('{addr, data, strb});
        #1;
        checks++;
        if (bus.stall !== 1'b1 || bus.wr_req !== 1'b0 || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s issue: stall=%b wr_req=%b resp_valid=%b, required 1 0 0",
                     name, bus.stall, bus.wr_req, bus.resp_valid);
        end
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            #1;
            if (bus.wr_req === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s write request: wr_req never rose, required 1", name);
            void'(wr_q.pop_back());
        end else begin
            exp_w = wr_q.pop_front();
            if (bus.wr_addr !== exp_w.addr || bus.wr_data !== exp_w.data || bus.wr_strb !== exp_w.strb) begin
                errors++;
                $display("FAIL %s write fields: got %h/%h/%b, required %h/%h/%b", name,
                         bus.wr_addr, bus.wr_data, bus.wr_strb, exp_w.addr, exp_w.data, exp_w.strb);
            end
            @(negedge clk);
            #1;
            checks++;
            if (bus.wr_req !== 1'b1 || bus.stall !== 1'b1 || bus.rd_req !== 1'b0) begin
                errors++;
                $display("FAIL %s write hold: wr_req=%b stall=%b rd_req=%b, required 1 1 0",
                         name, bus.wr_req, bus.stall, bus.rd_req);
            end
            bus.wr_ready = 1'b1;
            @(negedge clk);
            bus.wr_ready = 1'b0;
            #1;
            checks++;
            if (bus.stall !== 1'b0 || bus.wr_req !== 1'b0 || bus.resp_valid !== 1'b0 || bus.rd_req !== 1'b0) begin
                errors++;
                $display("FAIL %s write done: stall=%b wr_req=%b resp_valid=%b rd_req=%b, required 0 0 0 0",
                         name, bus.stall, bus.wr_req, bus.resp_valid, bus.rd_req);
            end
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst           = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_1000;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.resp_valid !== 1'b0 || bus.rd_req !== 1'b0 || bus.wr_req !== 1'b0 ||
            bus.resp_rdata !== 32'h0 || bus.rd_addr !== 32'h0 || bus.wr_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset outputs: stall=%b resp_valid=%b rd_req=%b wr_req=%b, required all 0",
                     bus.stall, bus.resp_valid, bus.rd_req, bus.wr_req);
        end
        @(negedge clk);
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.rd_req !== 1'b0 || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle after reset: stall=%b rd_req=%b resp_valid=%b, required 0 0 0",
                     bus.stall, bus.rd_req, bus.resp_valid);
        end
    endtask

    task automatic test_load_miss();
        do_load("load miss 1000", 32'h0000_1000, 1'b0, 32'hA0, 32'hA0);
    endtask

    task automatic test_load_hit();
        do_load("load hit 1004", 32'h0000_1004, 1'b1, 32'h0, 32'hA1);
        do_load("load hit 100C", 32'h0000_100C, 1'b1, 32'h0, 32'hA3);
    endtask

    task automatic test_store_hit();
        do_store("store hit 1008", 32'h0000_1008, 32'hFFFF_1234, 4'b0011);
        do_load("load merged 1008", 32'h0000_1008, 1'b1, 32'h0, 32'h0000_1234);
    endtask

    task automatic test_store_miss();
        do_store("store miss 3000", 32'h0000_3000, 32'hDEAD_BEEF, 4'b1111);
        do_load("load after store miss 3000", 32'h0000_3000, 1'b0, 32'hD0, 32'hD0);
    endtask

    task automatic test_conflict();
        do_load("conflict load 2000", 32'h0000_2000, 1'b0, 32'hB0, 32'hB0);
        do_load("hit 2008", 32'h0000_2008, 1'b1, 32'h0, 32'hB2);
        do_load("evicted 1000", 32'h0000_1000, 1'b0, 32'hE0, 32'hE0);
    endtask

    task automatic test_reset_mid_refill();
        bit seen;
        do_load("index1 load 1010", 32'h0000_1010, 1'b0, 32'h50, 32'h50);
        do_load("index1 hit 1014", 32'h0000_1014, 1'b1, 32'h0, 32'h51);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0000_2000;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            #1;
            if (bus.rd_req === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset-mid-refill request: rd_req never rose, required 1");
        end
        bus.rd_ready = 1'b1;
        @(negedge clk);
        bus.rd_ready = 1'b0;
        bus.rd_valid = 1'b1;
        bus.rd_data  = 32'hC0;
        @(negedge clk);
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.rd_data   = 32'hC1;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.rd_req !== 1'b0 || bus.resp_valid !== 1'b0 || bus.wr_req !== 1'b0) begin
            errors++;
            $display("FAIL reset during refill: stall=%b rd_req=%b resp_valid=%b wr_req=%b, required 0 0 0 0",
                     bus.stall, bus.rd_req, bus.resp_valid, bus.wr_req);
        end
        @(negedge clk);
        rst          = 1'b0;
        bus.rd_valid = 1'b0;
        bus.rd_data  = '0;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.rd_req !== 1'b0 || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL after reset: stall=%b rd_req=%b resp_valid=%b, required 0 0 0",
                     bus.stall, bus.rd_req, bus.resp_valid);
        end
        do_load("reload 1000 after reset", 32'h0000_1000, 1'b0, 32'h60, 32'h60);
        do_load("reset cleared 1010", 32'h0000_1010, 1'b0, 32'h70, 32'h70);
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] exp_v;
        addrs[0] = 32'h0000_1000;
        addrs[1] = 32'h0000_1004;
        addrs[2] = 32'h0000_100C;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b0;
            bus.req_addr  = addrs[i];
            exp_q.push_back(32'h60 + 32'(addrs[i][3:2]));
            #1;
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.stall !== 1'b0 || exp_q.size() == 0) begin
                errors++;
                $display("FAIL back-to-back %0d: resp_valid=%b stall=%b, required 1 0", i, bus.resp_valid, bus.stall);
            end else begin
                exp_v = exp_q.pop_front();
                if (bus.resp_rdata !== exp_v) begin
                    errors++;
                    $display("FAIL back-to-back %0d rdata: got %h, required %h", i, bus.resp_rdata, exp_v);
                end
            end
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        do_store("partial store 1004", 32'h0000_1004, 32'h1122_3344, 4'b1010);
        do_load("load partial 1004", 32'h0000_1004, 1'b1, 32'h0, 32'h1100_3361);
    endtask

    initial begin
        test_reset();
        test_load_miss();
        test_load_hit();
        test_store_hit();
        test_store_miss();
        test_conflict();
        test_reset_mid_refill();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d loads and %0d writes outstanding, required 0 0",
                     exp_q.size(), wr_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
